otter_intr_ctrl: RTL and testbench

//  Interrupt controller on the far end of the CU intr/int_taken handshake.
//  - Collects NUM_SRC external interrupt lines, masks them and prioritises them.
//  - Presents a single registered intr to the control-unit FSM and retires it on int_taken.
//  - Software manages enables, pending bits, cause and end-of-interrupt through a small MMIO register file.

---
 rtl/otter_intr_ctrl.sv | 133 +++++++++++++
 tb/tb_otter_intr_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/otter_intr_ctrl.sv
// Interrupt controller behind the CU intr/int_taken handshake: synchronises,
// masks and prioritises NUM_SRC lines and exposes a 4-register MMIO file.
module otter_intr_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               int_taken,
  output logic               intr,
  input  logic               io_wr,
  input  logic               io_rd,
  input  logic [1:0]         io_addr,
  input  logic [31:0]        io_wdata,
  output logic [31:0]        io_rdata
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, s_prev, rise;
  logic [NUM_SRC-1:0] enable, mode, pending, pending_n, req, clr;
  logic               cause_valid, cause_valid_n;
  logic [3:0]         cause_id, cause_id_n, sel;
  logic               any_req, cur_req, take, eoi, w1c, intr_n;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign unused_wdata = ^io_wdata[31:NUM_SRC];

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev;
  assign req  = pending & enable;
  assign take = (state == ASSERT) && int_taken;
  assign w1c  = io_wr && (io_addr == 2'd1);
  assign eoi  = io_wr && (io_addr == 2'd2);

  always_comb begin
    sel     = '0;
    any_req = |req;
    for (int unsigned i = NUM_SRC; i > 0; i--)
      if (req[i-1]) sel = 4'(i - 1);
    cur_req = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (cause_id == 4'(i)) cur_req = req[i];
  end

  // Level sources track s; edge sources clear on W1C/int_taken, but a rising edge in the same cycle wins.
  always_comb begin
    clr = '0;
    if (w1c) clr = io_wdata[NUM_SRC-1:0];
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (take && (cause_id == 4'(i))) clr[i] = 1'b1;
    pending_n = (mode & s) | (~mode & ((pending & ~clr) | rise));
  end

  always_comb begin
    state_n       = state;
    cause_valid_n = cause_valid;
    cause_id_n    = cause_id;
    case (state)
      IDLE:
        if (any_req) begin
          cause_valid_n = 1'b1;
          cause_id_n    = sel;
          state_n       = ASSERT;
        end
      ASSERT:
        if (int_taken) begin
          state_n = SERVICE;
        end else if (!cur_req) begin
          cause_valid_n = 1'b0;
          cause_id_n    = '0;
          state_n       = IDLE;
        end
      SERVICE:
        if (eoi) begin
          cause_valid_n = 1'b0;
          cause_id_n    = '0;
          state_n       = IDLE;
        end
      default: state_n = IDLE;
    endcase
    intr_n = (state_n == ASSERT);
  end

  always_comb begin
    rd_val = '0;
    case (io_addr)
      2'd0: rd_val = {{(32-NUM_SRC){1'b0}}, enable};
      2'd1: rd_val = {{(32-NUM_SRC){1'b0}}, pending};
      2'd2: rd_val = {cause_valid, 27'd0, cause_id};
      2'd3: rd_val = {{(32-NUM_SRC){1'b0}}, mode};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state       <= IDLE;
      enable      <= '0;
      mode        <= '0;
      pending     <= '0;
      cause_valid <= 1'b0;
      cause_id    <= '0;
      intr        <= 1'b0;
      io_rdata    <= '0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      cause_valid <= cause_valid_n;
      cause_id    <= cause_id_n;
      intr        <= intr_n;
      if (io_wr && (io_addr == 2'd0)) enable <= io_wdata[NUM_SRC-1:0];
      if (io_wr && (io_addr == 2'd3)) mode   <= io_wdata[NUM_SRC-1:0];
      if (io_rd) io_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: per-cycle vector table plus hand-written
// sequences for async reset in the middle of a request.
module tb_otter_intr_ctrl;

  logic        clk = 1'b0;
  logic        RST_n;
  logic [7:0]  irq_src;
  logic        int_taken, io_wr, io_rd;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic        intr;
  logic [31:0] io_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  otter_intr_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .RST_n(RST_n), .irq_src(irq_src), .int_taken(int_taken),
    .intr(intr), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  irq;
    logic        take;
    logic        exp_intr;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] addr,
                              input logic [31:0] wdata, input logic [7:0] irq,
                              input logic take, input logic exp_intr,
                              input logic chk_rd, input logic [31:0] exp_rd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.irq = irq;
    v.take = take; v.exp_intr = exp_intr; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [7:0] irq, input logic take);
    io_wr = wr; io_rd = rd; io_addr = addr; io_wdata = wdata; irq_src = irq; int_taken = take;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b1, addr, 32'd0, 8'd0, 1'b0);
    tick();
    check(name, io_rdata, exp);
  endtask

  initial begin
    bit seen;
    RST_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_intr", {31'd0, intr}, 32'd0);
    check("reset_rdata", io_rdata, 32'd0);
    RST_n = 1'b1;

    // reset values of all registers
    tbl.push_back(mk(0,1,2'd0,0,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(0,1,2'd3,0,8'h00,0,0,1,32'h0));
    // single edge source 0: latency, CAUSE, int_taken, EOI
    tbl.push_back(mk(1,0,2'd0,32'h01,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h01,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,1,1,32'h01));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,1,1,32'h8000_0000));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,1,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,0,1,32'h0));
    tbl.push_back(mk(1,1,2'd2,0,8'h00,0,0,1,32'h8000_0000));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,0,1,32'h0));
    // sources 5 and 2 together: 2 served first, then 5
    tbl.push_back(mk(1,0,2'd0,32'hFF,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h24,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,1,1,32'h24));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,1,1,32'h8000_0002));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,1,0,0,0));
    tbl.push_back(mk(1,0,2'd2,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,1,1,32'h8000_0005));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,1,0,0,0));
    tbl.push_back(mk(1,0,2'd2,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,0,1,32'h0));
    // level source 3: re-raise after EOI, then withdraw on drop
    tbl.push_back(mk(1,0,2'd3,32'h08,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd3,0,8'h00,0,0,1,32'h08));
    tbl.push_back(mk(0,0,2'd0,0,8'h08,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h08,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h08,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h08,0,1,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h08,1,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h08,0,0,0,0));
    tbl.push_back(mk(1,0,2'd2,0,8'h08,0,0,0,0));
    tbl.push_back(mk(0,1,2'd2,0,8'h08,0,1,1,32'h0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,1,1,32'h8000_0003));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,1,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd2,0,8'h00,0,0,1,32'h0));
    // edge on src 1 coinciding with W1C of bit 1: set wins
    tbl.push_back(mk(1,0,2'd0,32'h00,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h02,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,0,1,32'h02));
    tbl.push_back(mk(0,0,2'd0,0,8'h02,0,0,0,0));
    tbl.push_back(mk(0,0,2'd0,0,8'h00,0,0,0,0));
    tbl.push_back(mk(1,0,2'd1,32'h02,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,0,1,32'h02));
    tbl.push_back(mk(1,0,2'd1,32'h02,8'h00,0,0,0,0));
    tbl.push_back(mk(0,1,2'd1,0,8'h00,0,0,1,32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].irq, tbl[i].take);
      tick();
      check($sformatf("vec%0d_intr", i), {31'd0, intr}, {31'd0, tbl[i].exp_intr});
      if (tbl[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), io_rdata, tbl[i].exp_rd);
    end

    // async reset while intr is asserted
    drive(1'b1, 1'b0, 2'd0, 32'h01, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'd0, 8'h01, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'd0, 32'd0, 8'h00, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      io_rd = 1'b0;
      if (intr) seen = 1'b1;
    end
    check("rst_intr_up", {31'd0, seen}, 32'd1);
    check("rst_pre_rdata", io_rdata, 32'h01);
    #2 RST_n = 1'b0;
    #1;
    check("rst_intr_low", {31'd0, intr}, 32'd0);
    check("rst_rdata_low", io_rdata, 32'd0);
    #2 RST_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("rst_after%0d_intr", c), {31'd0, intr}, 32'd0);
    end
    read_chk("rst_enable", 2'd0, 32'd0);
    read_chk("rst_pending", 2'd1, 32'd0);
    read_chk("rst_cause", 2'd2, 32'd0);
    read_chk("rst_mode", 2'd3, 32'd0);
    check("rst_final_intr", {31'd0, intr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
